// File: rtl/cache_miss_ctrl_if.sv
// Cache-side, memory-side and counter signals of the miss controller.
// The slave modport is the controller's view; master is the cache/memory side.
interface cache_miss_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
);
  logic                     miss_valid_i;
  logic                     miss_ready_o;
  logic [ADDRESS_WIDTH-1:0] miss_addr_i;
  logic                     victim_dirty_i;
  logic [ADDRESS_WIDTH-1:0] victim_addr_i;
  logic [DATA_WIDTH-1:0]    victim_data_i;
  logic                     refill_valid_o;
  logic                     refill_ready_i;
  logic [ADDRESS_WIDTH-1:0] refill_addr_o;
  logic [DATA_WIDTH-1:0]    refill_data_o;
  logic                     mem_req_o;
  logic                     mem_we_o;
  logic [ADDRESS_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0]    mem_wdata_o;
  logic                     mem_ack_i;
  logic [DATA_WIDTH-1:0]    mem_rdata_i;
  logic                     busy_o;
  logic [CNT_WIDTH-1:0]     miss_cnt_o;
  logic [CNT_WIDTH-1:0]     wb_cnt_o;

  modport slave (
    input  miss_valid_i, miss_addr_i, victim_dirty_i, victim_addr_i, victim_data_i,
           refill_ready_i, mem_ack_i, mem_rdata_i,
    output miss_ready_o, refill_valid_o, refill_addr_o, refill_data_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, miss_cnt_o, wb_cnt_o
  );

  modport master (
    output miss_valid_i, miss_addr_i, victim_dirty_i, victim_addr_i, victim_data_i,
           refill_ready_i, mem_ack_i, mem_rdata_i,
    input  miss_ready_o, refill_valid_o, refill_addr_o, refill_data_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, miss_cnt_o, wb_cnt_o
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Single-line cache miss controller: optional dirty-victim writeback, line fill,
// then refill handshake back to the cache, with saturating miss/writeback counters.
module cache_miss_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cache_miss_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]    refill_data_q, refill_data_d;
  logic [CNT_WIDTH-1:0]     miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0]     wb_cnt_q, wb_cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      miss_addr_q   <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      refill_data_q <= '0;
      miss_cnt_q    <= '0;
      wb_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      miss_addr_q   <= miss_addr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      refill_data_q <= refill_data_d;
      miss_cnt_q    <= miss_cnt_d;
      wb_cnt_q      <= wb_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    miss_addr_d   = miss_addr_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    refill_data_d = refill_data_q;
    miss_cnt_d    = miss_cnt_q;
    wb_cnt_d      = wb_cnt_q;
    unique case (state_q)
      IDLE: if (bus.miss_valid_i) begin
        miss_addr_d = bus.miss_addr_i;
        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
        // The memory address register is preloaded with whichever address goes out first.
        if (bus.victim_dirty_i) begin
          mem_addr_d  = bus.victim_addr_i;
          mem_wdata_d = bus.victim_data_i;
          state_d     = WB;
        end else begin
          mem_addr_d  = bus.miss_addr_i;
          state_d     = FILL;
        end
      end
      WB: if (bus.mem_ack_i) begin
        mem_addr_d = miss_addr_q;
        if (wb_cnt_q != '1) wb_cnt_d = wb_cnt_q + 1'b1;
        state_d    = FILL;
      end
      FILL: if (bus.mem_ack_i) begin
        refill_data_d = bus.mem_rdata_i;
        state_d       = RESP;
      end
      RESP: if (bus.refill_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.miss_ready_o   = (state_q == IDLE);
  assign bus.busy_o         = (state_q != IDLE);
  assign bus.mem_req_o      = (state_q == WB) || (state_q == FILL);
  assign bus.mem_we_o       = (state_q == WB);
  assign bus.mem_addr_o     = mem_addr_q;
  assign bus.mem_wdata_o    = mem_wdata_q;
  assign bus.refill_valid_o = (state_q == RESP);
  assign bus.refill_addr_o  = miss_addr_q;
  assign bus.refill_data_o  = refill_data_q;
  assign bus.miss_cnt_o     = miss_cnt_q;
  assign bus.wb_cnt_o       = wb_cnt_q;
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl: clean/dirty misses, stalls, spurious acks,
// mid-transaction reset, and counter saturation on a narrow-counter instance.
module tb_cache_miss_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cache_miss_ctrl_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) a ();
  cache_miss_ctrl_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(2))  b ();

  cache_miss_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(a.slave));
  cache_miss_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .bus(b.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a.miss_valid_i = 0; a.miss_addr_i = '0; a.victim_dirty_i = 0;
    a.victim_addr_i = '0; a.victim_data_i = '0; a.refill_ready_i = 0;
    a.mem_ack_i = 0; a.mem_rdata_i = '0;
    b.miss_valid_i = 0; b.miss_addr_i = '0; b.victim_dirty_i = 0;
    b.victim_addr_i = '0; b.victim_data_i = '0; b.refill_ready_i = 0;
    b.mem_ack_i = 0; b.mem_rdata_i = '0;

    // Reset state
    #12;
    chk("rst_ready", a.miss_ready_o, 1);
    chk("rst_busy", a.busy_o, 0);
    chk("rst_rvalid", a.refill_valid_o, 0);
    chk("rst_req", a.mem_req_o, 0);
    chk("rst_we", a.mem_we_o, 0);
    chk("rst_maddr", a.mem_addr_o, 0);
    chk("rst_rdata", a.refill_data_o, 0);
    chk("rst_misscnt", a.miss_cnt_o, 0);
    chk("rst_wbcnt", a.wb_cnt_o, 0);
    rst_n = 1;

    // Clean miss, zero-wait fill
    a.miss_valid_i = 1; a.miss_addr_i = 32'h100; a.victim_dirty_i = 0;
    step();
    chk("c_fill_req", a.mem_req_o, 1);
    chk("c_fill_we", a.mem_we_o, 0);
    chk("c_fill_addr", a.mem_addr_o, 32'h100);
    chk("c_busy", a.busy_o, 1);
    chk("c_ready", a.miss_ready_o, 0);
    chk("c_misscnt", a.miss_cnt_o, 1);
    a.miss_valid_i = 0; a.miss_addr_i = 32'hBAD;
    a.mem_ack_i = 1; a.mem_rdata_i = 32'hDEADBEEF;
    step();
    chk("c_rvalid", a.refill_valid_o, 1);
    chk("c_rdata", a.refill_data_o, 32'hDEADBEEF);
    chk("c_raddr", a.refill_addr_o, 32'h100);
    chk("c_resp_req", a.mem_req_o, 0);
    a.mem_ack_i = 0; a.refill_ready_i = 1;
    a.miss_valid_i = 1; a.miss_addr_i = 32'h180;
    step();
    chk("c_idle_ready", a.miss_ready_o, 1);
    chk("c_idle_rvalid", a.refill_valid_o, 0);
    chk("c_no_accept_on_resp", a.miss_cnt_o, 1);
    chk("c_wbcnt", a.wb_cnt_o, 0);
    a.miss_valid_i = 0; a.refill_ready_i = 0;

    // Dirty miss, zero-wait writeback then fill
    a.miss_valid_i = 1; a.miss_addr_i = 32'h300; a.victim_dirty_i = 1;
    a.victim_addr_i = 32'h200; a.victim_data_i = 32'h12345678;
    step();
    chk("d_wb_req", a.mem_req_o, 1);
    chk("d_wb_we", a.mem_we_o, 1);
    chk("d_wb_addr", a.mem_addr_o, 32'h200);
    chk("d_wb_wdata", a.mem_wdata_o, 32'h12345678);
    chk("d_wb_rvalid", a.refill_valid_o, 0);
    a.miss_valid_i = 0; a.victim_dirty_i = 0;
    a.victim_addr_i = 32'hFFFF; a.victim_data_i = 32'h0;
    a.mem_ack_i = 1; a.mem_rdata_i = 32'hCAFEF00D;
    step();
    chk("d_fill_we", a.mem_we_o, 0);
    chk("d_fill_addr", a.mem_addr_o, 32'h300);
    chk("d_wbcnt", a.wb_cnt_o, 1);
    chk("d_fill_rvalid", a.refill_valid_o, 0);
    step();
    chk("d_rvalid_3rd", a.refill_valid_o, 1);
    chk("d_rdata", a.refill_data_o, 32'hCAFEF00D);
    chk("d_raddr", a.refill_addr_o, 32'h300);
    a.mem_ack_i = 0; a.refill_ready_i = 1;
    step();
    a.refill_ready_i = 0;
    chk("d_idle_ready", a.miss_ready_o, 1);
    chk("d_idle_we", a.mem_we_o, 0);
    chk("d_idle_addr_hold", a.mem_addr_o, 32'h300);
    chk("d_idle_wdata_hold", a.mem_wdata_o, 32'h12345678);
    chk("d_misscnt", a.miss_cnt_o, 2);

    // Spurious acks in IDLE
    a.mem_ack_i = 1; a.mem_rdata_i = 32'h55;
    step(); step();
    chk("sp_idle_ready", a.miss_ready_o, 1);
    chk("sp_idle_req", a.mem_req_o, 0);
    chk("sp_idle_misscnt", a.miss_cnt_o, 2);
    chk("sp_idle_wbcnt", a.wb_cnt_o, 1);
    chk("sp_idle_rdata", a.refill_data_o, 32'hCAFEF00D);
    a.mem_ack_i = 0;

    // Stalled dirty miss: slow memory, slow cache
    a.miss_valid_i = 1; a.miss_addr_i = 32'h400; a.victim_dirty_i = 1;
    a.victim_addr_i = 32'h500; a.victim_data_i = 32'hA5A5A5A5;
    step();
    a.miss_valid_i = 0; a.miss_addr_i = 32'h0; a.victim_data_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("s_wb_we", a.mem_we_o, 1);
      chk("s_wb_addr", a.mem_addr_o, 32'h500);
      chk("s_wb_wdata", a.mem_wdata_o, 32'hA5A5A5A5);
      step();
    end
    a.mem_ack_i = 1;
    step();
    a.mem_ack_i = 0;
    chk("s_wbcnt", a.wb_cnt_o, 2);
    for (int i = 0; i < 5; i++) begin
      chk("s_fill_req", a.mem_req_o, 1);
      chk("s_fill_addr", a.mem_addr_o, 32'h400);
      chk("s_fill_rvalid", a.refill_valid_o, 0);
      step();
    end
    a.mem_ack_i = 1; a.mem_rdata_i = 32'h11223344;
    step();
    a.mem_ack_i = 0; a.mem_rdata_i = 32'h99;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) a.mem_ack_i = 1;
      else        a.mem_ack_i = 0;
      chk("s_resp_rvalid", a.refill_valid_o, 1);
      chk("s_resp_rdata", a.refill_data_o, 32'h11223344);
      chk("s_resp_raddr", a.refill_addr_o, 32'h400);
      chk("s_resp_ready", a.miss_ready_o, 0);
      chk("s_resp_wbcnt", a.wb_cnt_o, 2);
      step();
    end
    a.mem_ack_i = 0; a.refill_ready_i = 1;
    chk("s_hs_ready", a.miss_ready_o, 0);
    step();
    a.refill_ready_i = 0;
    chk("s_idle_ready", a.miss_ready_o, 1);
    chk("s_misscnt", a.miss_cnt_o, 3);

    // Reset in the middle of a fill
    a.miss_valid_i = 1; a.miss_addr_i = 32'h600; a.victim_dirty_i = 0;
    step();
    a.miss_valid_i = 0;
    chk("r_fill_req", a.mem_req_o, 1);
    #2 rst_n = 0;
    #1;
    chk("r_req_drop", a.mem_req_o, 0);
    chk("r_ready", a.miss_ready_o, 1);
    chk("r_misscnt", a.miss_cnt_o, 0);
    chk("r_wbcnt", a.wb_cnt_o, 0);
    chk("r_maddr", a.mem_addr_o, 0);
    #2 rst_n = 1;
    a.miss_valid_i = 1; a.miss_addr_i = 32'h700;
    step();
    a.miss_valid_i = 0;
    chk("r_post_addr", a.mem_addr_o, 32'h700);
    chk("r_post_misscnt", a.miss_cnt_o, 1);
    a.mem_ack_i = 1; a.mem_rdata_i = 32'h77;
    step();
    a.mem_ack_i = 0; a.refill_ready_i = 1;
    chk("r_post_rdata", a.refill_data_o, 32'h77);
    chk("r_post_rvalid", a.refill_valid_o, 1);
    step();
    a.refill_ready_i = 0;
    chk("r_post_idle", a.miss_ready_o, 1);

    // Saturation on 2-bit counters with back-to-back dirty misses
    for (int k = 1; k <= 5; k++) begin
      b.miss_valid_i = 1; b.victim_dirty_i = 1;
      b.miss_addr_i = 32'h1000 + k; b.victim_addr_i = 32'h2000 + k;
      step();
      b.miss_valid_i = 0; b.mem_ack_i = 1;
      step();
      step();
      b.mem_ack_i = 0; b.refill_ready_i = 1;
      chk("sat_rvalid", b.refill_valid_o, 1);
      step();
      b.refill_ready_i = 0;
      chk("sat_misscnt", b.miss_cnt_o, (k > 3) ? 3 : k);
      chk("sat_wbcnt", b.wb_cnt_o, (k > 3) ? 3 : k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cache_miss_ctrl.md
CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 The module SHALL have parameter ADDRESS_WIDTH, default 32, meaning the byte address width on both the cache side and the memory side.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, meaning the width of one cache line (one word).
REQ-003 The module SHALL have parameter CNT_WIDTH, default 16, meaning the width of each performance counter.
REQ-004 The module SHALL use one clock and an asynchronous, active-low reset, with ports named clk_i and rst_ni.
REQ-005 The module SHALL have these ports, one per line as name, direction, width, meaning:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  asynchronous active-low reset
- miss_valid_i  in  1  cache presents a miss request
- miss_ready_o  out  1  controller can accept a miss request
- miss_addr_i  in  ADDRESS_WIDTH  address of the missing line
- victim_dirty_i  in  1  the chosen LRU victim way is valid and dirty
- victim_addr_i  in  ADDRESS_WIDTH  address of the victim line
- victim_data_i  in  DATA_WIDTH  data of the victim line
- refill_valid_o  out  1  refill data is available to the cache
- refill_ready_i  in  1  cache has taken the refill data
- refill_addr_o  out  ADDRESS_WIDTH  address of the refilled line
- refill_data_o  out  DATA_WIDTH  refilled line data
- mem_req_o  out  1  memory request active
- mem_we_o  out  1  1 = write (writeback), 0 = read (fill)
- mem_addr_o  out  ADDRESS_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  writeback data
- mem_ack_i  in  1  memory completes the current request this cycle
- mem_rdata_i  in  DATA_WIDTH  read data, valid when mem_ack_i is 1 and mem_we_o is 0
- busy_o  out  1  controller state is not IDLE
- miss_cnt_o  out  CNT_WIDTH  number of accepted misses
- wb_cnt_o  out  CNT_WIDTH  number of completed writebacks

Function
REQ-006 The controller SHALL be a state machine with the states IDLE, WB, FILL and RESP.
REQ-007 miss_ready_o SHALL be 1 only in IDLE, and busy_o SHALL equal the inverse of miss_ready_o.
REQ-008 A miss SHALL be accepted in IDLE on any edge where miss_valid_i is 1.
- On acceptance, the controller SHALL register miss_addr_i, victim_dirty_i, victim_addr_i and victim_data_i.
- The next state SHALL be WB if victim_dirty_i is 1, and FILL otherwise.
REQ-009 In WB the outputs SHALL be: mem_req_o=1, mem_we_o=1, mem_addr_o=registered victim address, mem_wdata_o=registered victim data.
- These outputs SHALL be held stable until the edge on which mem_ack_i is 1.
- That edge SHALL move the state to FILL and increment wb_cnt_o.
REQ-010 In FILL the outputs SHALL be: mem_req_o=1, mem_we_o=0, mem_addr_o=registered miss address.
- On the edge where mem_ack_i is 1, the controller SHALL register mem_rdata_i into refill_data_o and move to RESP.
REQ-011 In RESP, refill_valid_o SHALL be 1 and refill_addr_o SHALL equal the registered miss address.
- refill_data_o and refill_addr_o SHALL be held stable until the edge on which refill_ready_i is 1.
- That edge SHALL move the state to IDLE.
REQ-012 mem_ack_i SHALL be ignored whenever mem_req_o is 0 (IDLE, RESP), and SHALL NOT change any state.
REQ-013 An ack SHALL be accepted on the first cycle of WB or FILL, giving zero added wait states.
REQ-014 Minimum latency from miss acceptance to refill_valid_o=1 SHALL be 2 cycles for a clean victim and 3 cycles for a dirty victim.
REQ-015 miss_cnt_o SHALL increment by 1 on each accepted miss.
REQ-016 Both counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-017 A new miss SHALL NOT be accepted in the same cycle that RESP completes.
- The earliest acceptance of a new miss SHALL be the cycle after the return to IDLE.
REQ-018 Inputs on the cache side SHALL be ignored outside the acceptance cycle, so later changes to them do not affect the transaction in flight.
REQ-019 In IDLE, mem_addr_o and mem_wdata_o SHALL hold their last values and mem_we_o SHALL be 0.

Reset
REQ-020 When rst_ni is 0, the controller SHALL asynchronously force:
- state = IDLE
- miss_ready_o=1, busy_o=0, refill_valid_o=0, mem_req_o=0, mem_we_o=0
- all address and data registers = 0
- miss_cnt_o=0, wb_cnt_o=0
REQ-021 A reset asserted in WB, FILL or RESP SHALL drop the transaction with no completion pulse, and mem_req_o SHALL fall in the same cycle as the reset.
REQ-022 After rst_ni rises, the controller SHALL accept a miss on the first rising edge.

Verification
REQ-023 Clean miss: miss_addr=0x100, victim_dirty=0, mem_ack 1 cycle after the request, rdata=0xDEADBEEF -> one FILL read at 0x100; refill_data=0xDEADBEEF; miss_cnt=1, wb_cnt=0.
REQ-024 Dirty miss: victim 0x200/0x12345678, miss 0x300 -> a write to 0x200 with 0x12345678, then a read of 0x300; refill_valid_o at the 3rd cycle after acceptance with zero-wait memory; wb_cnt=1.
REQ-025 Stalls: 5-cycle mem_ack delay, refill_ready held low 4 cycles -> mem and refill outputs stable throughout; miss_ready=0 until the cycle after the refill handshake.
REQ-026 Spurious mem_ack_i=1 in IDLE and RESP -> no state change and no counter change.
REQ-027 Reset asserted mid-FILL -> mem_req_o=0 immediately and counters=0; then a miss accepted on the first edge after release completes normally.
REQ-028 Counters preloaded to 0xFFFF, then a dirty miss -> both counters remain 0xFFFF.
